// File: rtl/assoc_sum_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : assoc_sum_seq_if
// Description : Operand/result handshake bundle for assoc_sum_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface assoc_sum_seq_if #(
    parameter int WIDTH = 13
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_left;
    logic [WIDTH-1:0] sum_right;
    logic             ovf_left;
    logic             ovf_right;
    logic             match;

    modport master (
        output in_valid, op_a, op_b, op_c, out_ready,
        input  in_ready, out_valid, sum_left, sum_right, ovf_left, ovf_right, match
    );

    modport slave (
        input  in_valid, op_a, op_b, op_c, out_ready,
        output in_ready, out_valid, sum_left, sum_right, ovf_left, ovf_right, match
    );
endinterface
`default_nettype wire

// File: rtl/assoc_sum_seq.sv
`default_nettype none
// ============================================================================
// Module      : assoc_sum_seq
// Description : Evaluates (a+b)+c and a+(b+c) through one shared adder.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_sum_seq #(
    parameter int WIDTH = 13
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    assoc_sum_seq_if.slave bus
);
    localparam int         c_MSB  = WIDTH - 1;
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_L1   = 3'd1;
    localparam logic [2:0] c_L2   = 3'd2;
    localparam logic [2:0] c_R1   = 3'd3;
    localparam logic [2:0] c_R2   = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_sum_left;
    logic [WIDTH-1:0] r_sum_right;
    logic             r_ovf_left;
    logic             r_ovf_right;
    logic             r_match;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_sum;
    logic             w_ov;

    // Operand steering into the single shared adder, one add per state.
    always_comb begin
        w_x = r_a;
        w_y = r_b;
        case (r_state)
            c_L2: begin
                w_x = r_t;
                w_y = r_c;
            end
            c_R1: begin
                w_x = r_b;
                w_y = r_c;
            end
            c_R2: begin
                w_x = r_a;
                w_y = r_t;
            end
            default: begin
                w_x = r_a;
                w_y = r_b;
            end
        endcase
    end

    assign w_sum = w_x + w_y;
    assign w_ov  = (w_x[c_MSB] == w_y[c_MSB]) && (w_sum[c_MSB] != w_x[c_MSB]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_t         <= '0;
            r_sum_left  <= '0;
            r_sum_right <= '0;
            r_ovf_left  <= 1'b0;
            r_ovf_right <= 1'b0;
            r_match     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_a         <= bus.op_a;
                        r_b         <= bus.op_b;
                        r_c         <= bus.op_c;
                        r_ovf_left  <= 1'b0;
                        r_ovf_right <= 1'b0;
                        r_state     <= c_L1;
                    end
                end
                c_L1: begin
                    r_t        <= w_sum;
                    r_ovf_left <= r_ovf_left | w_ov;
                    r_state    <= c_L2;
                end
                c_L2: begin
                    r_sum_left <= w_sum;
                    r_ovf_left <= r_ovf_left | w_ov;
                    r_state    <= c_R1;
                end
                c_R1: begin
                    r_t         <= w_sum;
                    r_ovf_right <= r_ovf_right | w_ov;
                    r_state     <= c_R2;
                end
                c_R2: begin
                    r_sum_right <= w_sum;
                    r_ovf_right <= r_ovf_right | w_ov;
                    // A mismatch here can only come from a datapath fault.
                    r_match     <= (r_sum_left == w_sum);
                    r_state     <= c_DONE;
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.sum_left  = r_sum_left;
    assign bus.sum_right = r_sum_right;
    assign bus.ovf_left  = r_ovf_left;
    assign bus.ovf_right = r_ovf_right;
    assign bus.match     = r_match;
endmodule
`default_nettype wire

// File: tb/tb_assoc_sum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_assoc_sum_seq
// Description : Randomized self-checking bench for assoc_sum_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_sum_seq;
    localparam int W    = 13;
    localparam int HALF = 1 << (W - 1);
    localparam int MODV = 1 << W;

    logic clk;
    logic rst_n;
    int   cycle;
    int   n_checks;
    int   n_errors;

    assoc_sum_seq_if #(.WIDTH(W)) bus ();

    assoc_sum_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int wrap(input int v);
        int m;
        m = v % MODV;
        if (m < 0) m += MODV;
        if (m >= HALF) m -= MODV;
        return m;
    endfunction

    function automatic bit out_of_range(input int v);
        return (v < -HALF) || (v > HALF - 1);
    endfunction

    // Reference: exact integer sums, overflow = true intermediate leaves the signed range.
    task automatic model(input int a, input int b, input int c,
                         output logic [W-1:0] sl, output logic [W-1:0] sr,
                         output logic ol, output logic orr);
        int t;
        int s;
        t   = a + b;
        ol  = out_of_range(t);
        s   = wrap(t) + c;
        ol  = ol | out_of_range(s);
        sl  = W'(wrap(s));
        t   = b + c;
        orr = out_of_range(t);
        s   = a + wrap(t);
        orr = orr | out_of_range(s);
        sr  = W'(wrap(s));
    endtask

    function automatic int rand_op();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return -HALF;
        if (sel == 1) return HALF - 1;
        return int'($urandom_range(0, MODV - 1)) - HALF;
    endfunction

    task automatic drive_ops(input int a, input int b, input int c);
        bus.op_a = a[W-1:0];
        bus.op_b = b[W-1:0];
        bus.op_c = c[W-1:0];
    endtask

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic handshake(input int a, input int b, input int c, output int hs_cycle);
        drive_ops(a, b, c);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40 && !bus.in_ready; k++) @(negedge clk);
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        hs_cycle = cycle;
    endtask

    task automatic expect_result(input int a, input int b, input int c);
        logic [W-1:0] esl, esr;
        logic         eol, eor;
        int           lat;
        model(a, b, c, esl, esr, eol, eor);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 32'd4);
        check("sum_left", 32'(bus.sum_left), 32'(esl));
        check("sum_right", 32'(bus.sum_right), 32'(esr));
        check("ovf_left", 32'(bus.ovf_left), 32'(eol));
        check("ovf_right", 32'(bus.ovf_right), 32'(eor));
        check("match", 32'(bus.match), 32'd1);
    endtask

    // Full transaction with `hold` cycles of backpressure while junk is offered.
    task automatic run_triple(input int a, input int b, input int c, input int hold);
        int hs;
        bus.out_ready = (hold == 0);
        handshake(a, b, c, hs);
        bus.in_valid = 1'b0;
        expect_result(a, b, c);
        if (hold > 0) begin
            logic [W-1:0] sl0, sr0;
            logic         ol0, or0;
            sl0 = bus.sum_left;
            sr0 = bus.sum_right;
            ol0 = bus.ovf_left;
            or0 = bus.ovf_right;
            for (int h = 0; h < hold; h++) begin
                bus.in_valid = 1'b1;
                drive_ops(rand_op(), rand_op(), rand_op());
                @(negedge clk);
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                check("hold_sum_left", 32'(bus.sum_left), 32'(sl0));
                check("hold_sum_right", 32'(bus.sum_right), 32'(sr0));
                check("hold_ovf", 32'({bus.ovf_left, bus.ovf_right}), 32'({ol0, or0}));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_sums"}, 32'({bus.sum_left, bus.sum_right}), 32'd0);
        check({tag, "_flags"}, 32'({bus.ovf_left, bus.ovf_right, bus.match}), 32'd0);
    endtask

    initial begin
        int hs;
        int prev_hs;
        int a, b, c;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_ops(0, 0, 0);
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_triple(-10, 100, 5, 0);
        run_triple(4095, 1, -1, 0);
        run_triple(-3210, 15, -1000, 0);
        run_triple(63, 127, 15, 10);

        // Reset while in R1 discards the in-flight triple.
        bus.out_ready = 1'b0;
        handshake(7, 8, 9, hs);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared("midrst");
        run_triple(1000, 2001, 0, 0);

        // Reset coinciding with a handshake: no capture may occur.
        drive_ops(11, 22, 33);
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check("rst_hs_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("rst_hs_no_result", 32'(bus.out_valid), 32'd0);

        // Back-to-back with in_valid and out_ready held high.
        bus.out_ready = 1'b1;
        prev_hs = 0;
        for (int i = 0; i < 3; i++) begin
            a = rand_op();
            b = rand_op();
            c = rand_op();
            handshake(a, b, c, hs);
            if (i > 0) check("b2b_interval", hs - prev_hs, 32'd6);
            prev_hs = hs;
            expect_result(a, b, c);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            run_triple(rand_op(), rand_op(), rand_op(), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cycle);
        $fatal(1);
    end
endmodule
`default_nettype wire
